// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
//   Shared constants and the stereo frame type for the I2S transmit path.
//   SAMPLE_W    : bits per channel sample
//   SLOT_W      : BCLKs per channel slot (frame = 2*SLOT_W BCLKs)
//   FIFO_DEPTH  : default frame buffer depth (power of 2, >= 2)
//   BCLK_HALF   : default clk cycles per BCLK half-period
//   audio_frame_t : {left, right}, left in the upper half of the packed word
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int BCLK_HALF  = 8;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// ----------------------------------------------------------------------------
// audio_sample_fifo
//   Synchronous show-ahead FIFO of stereo frames. rd_data always presents the
//   head entry; rd pops it. A write is refused while full, even in a cycle that
//   also pops. Simultaneous write and pop leave the level unchanged.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   wr, wr_data         : write request and frame
//   rd, rd_data         : pop request and head frame (valid when !empty)
//   full, empty, level  : occupancy status
// ----------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH,
    parameter type frame_t = audio_frame_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  frame_t                 wr_data,
    input  logic                   rd,
    output frame_t                 rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    frame_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign wr_en   = wr && !full;
    assign rd_en   = rd && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and level
    // decide which entries are valid, and an unreset array can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// ----------------------------------------------------------------------------
// audio_i2s_tx
//   I2S master serializer for the WM8731 DAC path. Stereo frames arrive over
//   valid/ready into a small FIFO; the serializer generates BCLK and LRCK and
//   shifts each sample MSB-first, one BCLK after the LRCK transition. When the
//   FIFO is empty at a frame start, silence is played and underflow pulses.
//
//   Optional feature: define AUDIO_TX_UFLOW_CNT_EN to build the saturating
//   underflow event counter; otherwise underflow_count is tied to zero.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   s_data, s_valid  : frame {left, right} and its valid
//   s_ready          : FIFO can accept a frame (= !full)
//   enable           : run the serializer; low holds the I2S outputs idle
//   bclk, lrclk      : I2S bit clock and word select (0 = left, 1 = right)
//   dacdat           : serial data, updated only on bclk falling edges
//   fifo_level       : frames currently stored
//   underflow        : one-clk pulse per frame start with an empty FIFO
//   underflow_count  : saturating count of underflow pulses (optional)
// ----------------------------------------------------------------------------
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = audio_pkg::FIFO_DEPTH,
    parameter int BCLK_HALF  = audio_pkg::BCLK_HALF,
    parameter int SLOT_W     = audio_pkg::SLOT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*SAMPLE_W-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enable,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic [15:0]                   underflow_count
);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

    localparam int               CNT_W    = $clog2(2 * SLOT_W);
    localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    // ------------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------------
    frame_t fifo_head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   frame_start;

    audio_sample_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .frame_t (frame_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (s_valid),
        .wr_data (frame_t'(s_data)),
        .rd      (frame_start),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign s_ready = !fifo_full;

    // ------------------------------------------------------------------------
    // Bit position decode for the next falling edge
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_next;
    logic [CNT_W-1:0]    slot_pos;
    logic                in_right;
    logic                fall_edge;
    logic                next_bit;
    logic [SAMPLE_W-1:0] left_hold;
    logic [SAMPLE_W-1:0] right_hold;
    logic [SAMPLE_W-1:0] slot_word;

    assign fall_edge    = enable && bclk && (div_cnt == DIV_LAST);
    assign bit_cnt_next = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
    assign frame_start  = fall_edge && (bit_cnt == CNT_LAST);
    assign in_right     = (bit_cnt_next >= SLOT_LEN);
    assign slot_pos     = in_right ? (bit_cnt_next - SLOT_LEN) : bit_cnt_next;
    assign slot_word    = in_right ? right_hold : left_hold;

    // Slot position p in 1..SAMPLE_W carries sample bit SAMPLE_W-p; position 0
    // (the I2S one-BCLK delay) and the padding after the sample carry zero.
    // NOTE: next_bit gets a default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        next_bit = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (int'(slot_pos) == SAMPLE_W - i) begin
                next_bit = slot_word[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Clock divider, bit counter, hold registers and outputs.
    // Reset and idle share the same state so neither resumes a partial frame.
    // ------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= CNT_LAST;
            lrclk      <= 1'b0;
            dacdat     <= 1'b0;
            left_hold  <= '0;
            right_hold <= '0;
            underflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= !bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_edge) begin
                bit_cnt <= bit_cnt_next;
                lrclk   <= in_right;
                dacdat  <= next_bit;
            end

            // The new frame starts at position 0, which always sends zero, so
            // the hold registers can be loaded in the same clk.
            if (frame_start) begin
                if (fifo_empty) begin
                    left_hold  <= '0;
                    right_hold <= '0;
                    underflow  <= 1'b1;
                end else begin
                    left_hold  <= fifo_head.left;
                    right_hold <= fifo_head.right;
                end
            end
        end
    end

`ifdef AUDIO_TX_UFLOW_CNT_EN
    // Counts every underflow pulse, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_count <= '0;
        end else if (frame_start && fifo_empty && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`else
    assign underflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// ----------------------------------------------------------------------------
// tb_audio_i2s_tx
//   Directed bench for audio_i2s_tx. Accepted writes push their 64 expected
//   serial bits into a scoreboard queue; each bclk falling edge pops and
//   compares. A small model tracks FIFO level, frame position, silence frames
//   and the underflow counter.
// ----------------------------------------------------------------------------
module tb_audio_i2s_tx;

    localparam int SAMPLE_W   = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int BCLK_HALF  = 8;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 2 * SLOT_W;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [2*SAMPLE_W-1:0]       s_data = '0;
    logic                        s_valid = 1'b0;
    logic                        s_ready;
    logic                        enable = 1'b0;
    logic                        bclk;
    logic                        lrclk;
    logic                        dacdat;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        underflow;
    logic [15:0]                 underflow_count;

    audio_i2s_tx #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BCLK_HALF  (BCLK_HALF),
        .SLOT_W     (SLOT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .enable          (enable),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .dacdat          (dacdat),
        .fifo_level      (fifo_level),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;

    // Model state
    bit   exp_q[$];
    int   mdl_lvl   = 0;
    int   mdl_uf    = 0;
    int   fe_cnt    = 0;
    int   half_cnt  = 0;
    int   bits_left = 0;
    bit   silent    = 1'b1;
    logic prev_bclk = 1'b0;
    logic prev_lr   = 1'b0;
    logic prev_d    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    function automatic int exp_cnt();
`ifdef AUDIO_TX_UFLOW_CNT_EN
        return mdl_uf;
`else
        return 0;
`endif
    endfunction

    // Expected serial bits of one frame, position 0 first.
    task automatic push_frame(input logic [2*SAMPLE_W-1:0] f);
        logic [SAMPLE_W-1:0] w;
        int                  q;
        for (int p = 0; p < FRAME_BITS; p++) begin
            w = (p < SLOT_W) ? f[2*SAMPLE_W-1:SAMPLE_W] : f[SAMPLE_W-1:0];
            q = p % SLOT_W;
            exp_q.push_back((q >= 1 && q <= SAMPLE_W) ? w[SAMPLE_W-q] : 1'b0);
        end
    endtask

    // One clk: capture pre-edge inputs, advance, sample 1 ns later and check.
    task automatic step();
        int                    lvl_pre;
        bit                    en_pre;
        bit                    rst_pre;
        bit                    wr_pre;
        logic [2*SAMPLE_W-1:0] dat_pre;
        int                    pos;
        logic                  exp_d;
        lvl_pre = mdl_lvl;
        en_pre  = enable;
        rst_pre = reset;
        wr_pre  = s_valid;
        dat_pre = s_data;
        @(posedge clk);
        #1;
        if (rst_pre) begin
            mdl_lvl = 0; mdl_uf = 0; fe_cnt = 0; half_cnt = 0; bits_left = 0;
            silent = 1'b1; prev_bclk = 1'b0; prev_lr = 1'b0; prev_d = 1'b0;
            exp_q.delete();
            return;
        end
        if (!en_pre) begin
            // Disabling discards the rest of the frame in flight.
            repeat (bits_left) void'(exp_q.pop_front());
            bits_left = 0; fe_cnt = 0; half_cnt = 0;
            prev_bclk = 1'b0; prev_lr = 1'b0; prev_d = 1'b0;
        end else begin
            half_cnt++;
            if (bclk !== prev_bclk) begin
                check("bclk_half_period", half_cnt, BCLK_HALF);
                half_cnt = 0;
            end else if (half_cnt == BCLK_HALF + 1) begin
                bound_fail("bclk_stalled");
            end
            if (prev_bclk === 1'b1 && bclk === 1'b0) begin
                pos = fe_cnt % FRAME_BITS;
                if (pos == 0) begin
                    silent = (lvl_pre == 0);
                    if (silent) begin
                        if (mdl_uf != 16'hFFFF) mdl_uf++;
                    end else begin
                        mdl_lvl--;
                        bits_left = FRAME_BITS;
                    end
                    check("underflow_count", underflow_count, exp_cnt());
                end
                exp_d = 1'b0;
                if (bits_left > 0 && exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    bits_left--;
                end
                check("lrclk_fall", lrclk, (pos >= SLOT_W) ? 1 : 0);
                check("dacdat_fall", dacdat, exp_d);
                check("underflow_frame", underflow, (pos == 0 && silent) ? 1 : 0);
                fe_cnt++;
            end else begin
                check("lrclk_hold", lrclk, prev_lr);
                check("dacdat_hold", dacdat, prev_d);
                check("underflow_quiet", underflow, 0);
            end
            prev_bclk = bclk;
            prev_lr   = lrclk;
            prev_d    = dacdat;
        end
        if (wr_pre && lvl_pre < FIFO_DEPTH) begin
            mdl_lvl++;
            push_frame(dat_pre);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next clk edge is a frame-start falling edge.
    task automatic wait_pre_frame_start(input string tag);
        int n;
        n = 0;
        while (!(bclk === 1'b1 && half_cnt == BCLK_HALF - 1 && fe_cnt % FRAME_BITS == 0)) begin
            step();
            n++;
            if (n > 3000) begin
                bound_fail(tag);
                return;
            end
        end
    endtask

    task automatic write_frame(input logic [2*SAMPLE_W-1:0] f);
        s_data  = f;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        int n;

        // 1. Reset for 3 clks.
        reset = 1'b1;
        steps(3);
        reset = 1'b0;
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_dacdat", dacdat, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_underflow", underflow, 0);
        check("rst_underflow_count", underflow_count, 0);

        // 2. One frame, then play it and the following silent frame start.
        write_frame({16'h8001, 16'h7FFE});
        check("t2_level", fifo_level, 1);
        enable = 1'b1;
        steps(2 * BCLK_HALF + FRAME_BITS * 2 * BCLK_HALF);
        check("t2_level_drained", fifo_level, 0);
        enable = 1'b0;
        step();
        check("idle_bclk", bclk, 0);
        check("idle_lrclk", lrclk, 0);
        check("idle_dacdat", dacdat, 0);

        // 3. Nine back-to-back writes while idle; the ninth is refused.
        for (int i = 0; i < 9; i++) begin
            s_data  = {16'hA5A5 ^ 16'(i * 16'h1357), 16'(i * 16'h0F0F + 1)};
            s_valid = 1'b1;
            step();
            check("t3_s_ready", s_ready, (mdl_lvl < FIFO_DEPTH) ? 1 : 0);
            if (i == 7) check("t3_full_after_8", s_ready, 0);
        end
        s_valid = 1'b0;
        step();
        check("t3_level_full", fifo_level, 8);

        // Play the eight stored frames, then 4. three silent frames.
        enable = 1'b1;
        steps(2 * BCLK_HALF + 11 * FRAME_BITS * 2 * BCLK_HALF);
        check("t4_level_empty", fifo_level, 0);
        check("t4_dacdat_silent", dacdat, 0);
        check("t4_underflow_count", underflow_count, exp_cnt());
        enable = 1'b0;
        step();

        // 5. Reset mid-frame at bit_cnt 20 with three frames left.
        for (int i = 0; i < 4; i++) write_frame({16'h1234 + 16'(i), 16'hFEDC - 16'(i)});
        enable = 1'b1;
        n = 0;
        while (fe_cnt < 21 && n < 2000) begin
            step();
            n++;
        end
        if (fe_cnt < 21) bound_fail("t5_reach_bit20");
        check("t5_level_before_reset", fifo_level, 3);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        check("t5_bclk", bclk, 0);
        check("t5_lrclk", lrclk, 0);
        check("t5_dacdat", dacdat, 0);
        check("t5_level", fifo_level, 0);
        check("t5_s_ready", s_ready, 1);
        check("t5_underflow", underflow, 0);
        check("t5_underflow_count", underflow_count, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5_bclk_quiet", bclk, 0);
        end

        // 6a. Level 1, write coincident with the frame-start pop.
        write_frame({16'hC3C3, 16'h0F0F});
        enable = 1'b1;
        wait_pre_frame_start("t6a_wait");
        write_frame({16'h5A5A, 16'hFFFF});
        check("t6a_level", fifo_level, 1);
        check("t6a_no_underflow", underflow, 0);

        // 6b. Write into an empty FIFO on a frame start.
        wait_pre_frame_start("t6b_wait_pop");
        step();
        check("t6b_level_empty", fifo_level, 0);
        wait_pre_frame_start("t6b_wait_empty");
        write_frame({16'h8000, 16'h0001});
        check("t6b_underflow", underflow, 1);
        check("t6b_level", fifo_level, 1);
        check("t6b_underflow_count", underflow_count, exp_cnt());

        // Play the late frame and confirm its bits via the scoreboard.
        wait_pre_frame_start("t6b_wait_play");
        step();
        wait_pre_frame_start("t6b_wait_end");
        check("t6b_level_end", fifo_level, 0);
        enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
